// File: rtl/im_boot_pkg.sv
// im_boot_pkg: shared types and constants for the instruction-memory boot
// controller. The instruction memory is 8k words of 17 bits, loaded from a
// byte stream that packs each word into three bytes, least significant first.
package im_boot_pkg;

    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 17;
    localparam int unsigned MEM_DEPTH       = 8192;
    localparam int unsigned BYTES_PER_WORD  = 3;
    localparam int unsigned TIMEOUT_CYC_DEF = 1000000;

    // Number of instruction bits carried by the last byte of a word; the
    // remaining bits of that byte are padding and are dropped.
    localparam int unsigned TOP_BITS = DATA_W - 8 * (BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_B0     = 3'd3,
        ST_B1     = 3'd4,
        ST_B2     = 3'd5,
        ST_WRITE  = 3'd6,
        ST_ERR    = 3'd7
    } boot_state_e;

    // True in the states that consume one byte from the UART.
    function automatic logic is_byte_state(input boot_state_e st);
        logic res;
        case (st)
            ST_HDR_LO, ST_HDR_HI, ST_B0, ST_B1, ST_B2: res = 1'b1;
            default:                                  res = 1'b0;
        endcase
        return res;
    endfunction

    // Packs the three received bytes into one instruction word.
    function automatic logic [DATA_W-1:0] assemble_word(
        input logic [7:0] b2,
        input logic [7:0] b1,
        input logic [7:0] b0
    );
        return {b2[TOP_BITS-1:0], b1, b0};
    endfunction

endpackage

// File: rtl/im_boot_timer.sv
// im_boot_timer: idle counter for the boot link. Counts enabled cycles,
// saturates at the last count and flags expiry while still enabled there.
module im_boot_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance while enabled and not saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/im_boot_ctrl.sv
// im_boot_ctrl: owns the instruction-memory address/control port. In RUN the
// CPU fetch port passes straight through; on boot_req the CPU is stalled and a
// length-prefixed program arrives byte-wise from the UART and is written to IM
// from address 0. A bad header or an idle link parks the block in ERR until
// the next boot_req.
module im_boot_ctrl
    import im_boot_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_req,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_clr_rdy,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd_en,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_rd_en,
    output logic              im_we,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_stall,
    output logic              boot_busy,
    output logic              boot_done,
    output logic              boot_err,
    output logic [15:0]       words_loaded
);

    localparam logic [15:0] MAX_COUNT = 16'(MEM_DEPTH);

    boot_state_e       state_q, state_d;
    logic [15:0]       count_q, count_d;
    // Words written so far; doubles as the IM write pointer since both start
    // at zero and advance together on every WRITE.
    logic [15:0]       words_q, words_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [7:0]        byte1_q, byte1_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              stall_q, stall_d;
    logic              busy_q, busy_d;

    logic              byte_ok_s;
    logic              req_ok_s;
    logic              tmr_en_s;
    logic              tmr_clr_s;
    logic              tmo_s;
    logic [15:0]       hdr_count_s;
    logic [15:0]       words_inc_s;

    assign byte_ok_s   = is_byte_state(state_q) && rx_rdy;
    assign req_ok_s    = boot_req && ((state_q == ST_RUN) || (state_q == ST_ERR));
    assign tmr_en_s    = is_byte_state(state_q) && !rx_rdy;
    assign tmr_clr_s   = byte_ok_s || req_ok_s;
    assign hdr_count_s = {rx_data, count_q[7:0]};
    assign words_inc_s = words_q + 16'd1;

    im_boot_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clr_s),
        .enable (tmr_en_s),
        .expire (tmo_s)
    );

    // Next-state, data capture and registered-output decode.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        byte0_d = byte0_q;
        byte1_d = byte1_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (boot_req) begin
                    state_d = ST_HDR_LO;
                    words_d = 16'd0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HDR_LO: begin
                if (rx_rdy) begin
                    count_d = {count_q[15:8], rx_data};
                    state_d = ST_HDR_HI;
                end else if (tmo_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_HI: begin
                if (rx_rdy) begin
                    count_d = hdr_count_s;
                    if (hdr_count_s == 16'd0) begin
                        // Empty program: nothing to write, hand fetch back.
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else if (hdr_count_s > MAX_COUNT) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_B0;
                    end
                end else if (tmo_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_HDR_HI;
                end
            end
            ST_B0: begin
                if (rx_rdy) begin
                    byte0_d = rx_data;
                    state_d = ST_B1;
                end else if (tmo_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_B0;
                end
            end
            ST_B1: begin
                if (rx_rdy) begin
                    byte1_d = rx_data;
                    state_d = ST_B2;
                end else if (tmo_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_B1;
                end
            end
            ST_B2: begin
                if (rx_rdy) begin
                    wdata_d = assemble_word(rx_data, byte1_q, byte0_q);
                    state_d = ST_WRITE;
                end else if (tmo_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_B2;
                end
            end
            ST_WRITE: begin
                words_d = words_inc_s;
                if (words_inc_s == count_q) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_B0;
                end
            end
            ST_ERR: begin
                if (boot_req) begin
                    state_d = ST_HDR_LO;
                    words_d = 16'd0;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        // Status outputs are registered copies of what the next state implies,
        // so they line up exactly with state_q on the following cycle.
        we_d    = (state_d == ST_WRITE);
        stall_d = (state_d != ST_RUN);
        err_d   = (state_d == ST_ERR);
        busy_d  = (state_d != ST_RUN) && (state_d != ST_ERR);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            count_q <= 16'd0;
            words_q <= 16'd0;
            byte0_q <= 8'd0;
            byte1_q <= 8'd0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            words_q <= words_d;
            byte0_q <= byte0_d;
            byte1_q <= byte1_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
        end
    end

    // IM port mux: CPU fetch passes through in RUN, write pointer otherwise.
    always_comb begin
        if (state_q == ST_RUN) begin
            im_addr  = cpu_addr;
            im_rd_en = cpu_rd_en;
        end else begin
            im_addr  = words_q;
            im_rd_en = 1'b0;
        end
    end

    // The consume pulse must land in the same cycle the byte is offered.
    assign rx_clr_rdy   = byte_ok_s;
    assign im_we        = we_q;
    assign im_wdata     = wdata_q;
    assign cpu_stall    = stall_q;
    assign boot_busy    = busy_q;
    assign boot_done    = done_q;
    assign boot_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_im_boot_ctrl.sv
// tb_im_boot_ctrl: randomized self-checking bench for im_boot_ctrl. Expected
// results come from a stream-level model: header -> word count, every three
// bytes -> one 17-bit word written at consecutive addresses from 0.
module tb_im_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_req = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_clr_rdy;
    logic [15:0] cpu_addr = 16'd0;
    logic        cpu_rd_en = 1'b0;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic        im_we;
    logic [16:0] im_wdata;
    logic        cpu_stall;
    logic        boot_busy;
    logic        boot_done;
    logic        boot_err;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    // Monitor state (written only by the monitor process).
    int neg_cyc = 0;
    int acc_n = 0;
    int we_n = 0;
    int done_n = 0;
    int third_neg = -10;
    int load_idx = 0;
    int seen_id = 0;
    int wr_addr[$];
    logic [16:0] wr_data[$];

    // Incremented by the stimulus every time a honoured boot_req is issued.
    int req_id = 0;

    logic [7:0] prog[$];

    always #5 clk = ~clk;

    im_boot_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .boot_req     (boot_req),
        .rx_rdy       (rx_rdy),
        .rx_data      (rx_data),
        .rx_clr_rdy   (rx_clr_rdy),
        .cpu_addr     (cpu_addr),
        .cpu_rd_en    (cpu_rd_en),
        .im_addr      (im_addr),
        .im_rd_en     (im_rd_en),
        .im_we        (im_we),
        .im_wdata     (im_wdata),
        .cpu_stall    (cpu_stall),
        .boot_busy    (boot_busy),
        .boot_done    (boot_done),
        .boot_err     (boot_err),
        .words_loaded (words_loaded)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: byte acceptances, write latency, IM writes and done pulses.
    always @(negedge clk) begin : mon
        automatic int idx_now;
        idx_now = (req_id != seen_id) ? 0 : load_idx;
        seen_id <= req_id;
        neg_cyc <= neg_cyc + 1;
        if (rx_clr_rdy === 1'b1) begin
            acc_n <= acc_n + 1;
            idx_now = idx_now + 1;
            if (idx_now >= 5 && ((idx_now - 2) % 3) == 0) third_neg <= neg_cyc;
        end
        load_idx <= idx_now;
        if (im_we === 1'b1) begin
            check("we_latency", neg_cyc, third_neg + 1);
            check("clr_in_write", 32'(rx_clr_rdy), 32'(1'b0));
            wr_addr.push_back(int'(im_addr));
            wr_data.push_back(im_wdata);
            we_n <= we_n + 1;
        end
        if (boot_done === 1'b1) done_n <= done_n + 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_req();
        req_id++;
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; optionally poke boot_req mid-load.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            rx_rdy   = 1'b0;
            boot_req = poke && (g == 0);
            tick();
        end
        boot_req = 1'b0;
        rx_rdy   = 1'b1;
        rx_data  = b;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (rx_clr_rdy === 1'b1) ok = 1'b1;
            tick();
        end
        check("byte_accept", 32'(ok), 32'(1'b1));
    endtask

    // Random program of cnt words; last byte of each word has random padding.
    task automatic build(input int cnt);
        prog.delete();
        prog.push_back(8'(cnt));
        prog.push_back(8'(cnt >> 8));
        for (int i = 0; i < 3 * cnt; i++) prog.push_back(8'($urandom));
    endtask

    // Full load against the stream-level model.
    task automatic run_load(input logic [7:0] bytes[$], input int gap_max, input bit pokes);
        int cnt;
        bit exp_err;
        int n_send;
        int acc0, we0, done0;
        logic [16:0] exp_w[$];
        cnt     = int'({bytes[1], bytes[0]});
        exp_err = (cnt > 8192);
        if (!exp_err) begin
            for (int i = 0; i < cnt; i++)
                exp_w.push_back({bytes[4 + 3 * i][0], bytes[3 + 3 * i], bytes[2 + 3 * i]});
        end
        n_send = (exp_err || cnt == 0) ? 2 : 2 + 3 * cnt;
        acc0 = acc_n; we0 = we_n; done0 = done_n;
        pulse_req();
        for (int i = 0; i < n_send; i++)
            send_byte(bytes[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0,
                      pokes && ($urandom_range(3, 0) == 0));
        rx_rdy = 1'b0;
        repeat (3) tick();
        check("acc_count", acc_n - acc0, n_send);
        check("we_count", we_n - we0, exp_w.size());
        check("done_count", done_n - done0, exp_err ? 0 : 1);
        check("boot_err", 32'(boot_err), 32'(exp_err));
        check("cpu_stall", 32'(cpu_stall), 32'(exp_err));
        check("boot_busy", 32'(boot_busy), 32'(1'b0));
        if (!exp_err) check("words_loaded", 32'(words_loaded), cnt);
        foreach (exp_w[i]) begin
            if (we0 + i < wr_data.size()) begin
                check("wr_addr", wr_addr[we0 + i], i);
                check("wr_data", 32'(wr_data[we0 + i]), 32'(exp_w[i]));
            end
        end
    endtask

    logic [7:0] dir_prog [8] = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'hCD, 8'hAB, 8'h00};

    initial begin : main
        int we0;
        int nw;
        // Reset values while rst_n is held low.
        repeat (3) tick();
        rx_rdy = 1'b1;
        rx_data = 8'h55;
        #1;
        check("rst_clr", 32'(rx_clr_rdy), 32'(1'b0));
        check("rst_we", 32'(im_we), 32'(1'b0));
        check("rst_stall", 32'(cpu_stall), 32'(1'b0));
        check("rst_busy", 32'(boot_busy), 32'(1'b0));
        check("rst_done", 32'(boot_done), 32'(1'b0));
        check("rst_err", 32'(boot_err), 32'(1'b0));
        check("rst_wdata", 32'(im_wdata), 32'(17'd0));
        check("rst_words", 32'(words_loaded), 32'(16'd0));
        rst_n = 1'b1;
        tick();
        check("run_no_consume", 32'(rx_clr_rdy), 32'(1'b0));
        rx_rdy = 1'b0;

        // Pass-through.
        cpu_addr = 16'h0123;
        cpu_rd_en = 1'b1;
        #1;
        check("pt_addr", 32'(im_addr), 32'(16'h0123));
        check("pt_rd", 32'(im_rd_en), 32'(1'b1));
        check("pt_stall", 32'(cpu_stall), 32'(1'b0));
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 16'($urandom);
            cpu_rd_en = 1'($urandom);
            tick();
            check("pt_addr_r", 32'(im_addr), 32'(cpu_addr));
            check("pt_rd_r", 32'(im_rd_en), 32'(cpu_rd_en));
        end
        check("pt_no_we", we_n, 0);
        cpu_rd_en = 1'b0;

        // Directed two-word load.
        prog.delete();
        foreach (dir_prog[i]) prog.push_back(dir_prog[i]);
        run_load(prog, 0, 1'b0);
        nw = wr_data.size();
        if (nw >= 2) begin
            check("dir_w0", 32'(wr_data[nw - 2]), 32'(17'h11234));
            check("dir_w1", 32'(wr_data[nw - 1]), 32'(17'h0ABCD));
        end
        check("dir_words", 32'(words_loaded), 32'(16'd2));

        // Zero-length header.
        build(0);
        run_load(prog, 1, 1'b0);

        // Oversize header 8193 -> ERR, further bytes left unconsumed.
        prog.delete();
        prog.push_back(8'h01);
        prog.push_back(8'h20);
        run_load(prog, 0, 1'b0);
        rx_rdy = 1'b1;
        rx_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("err_no_consume", 32'(rx_clr_rdy), 32'(1'b0));
            tick();
        end
        rx_rdy = 1'b0;
        check("err_stall", 32'(cpu_stall), 32'(1'b1));
        check("err_sticky", 32'(boot_err), 32'(1'b1));
        build(2);
        run_load(prog, 2, 1'b0);

        // Timeout: stall after the first data byte, 16 idle cycles to ERR.
        pulse_req();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h5A, 0, 1'b0);
        rx_rdy = 1'b0;
        repeat (15) tick();
        @(negedge clk);
        check("tmo_early_err", 32'(boot_err), 32'(1'b0));
        check("tmo_early_busy", 32'(boot_busy), 32'(1'b1));
        tick();
        @(negedge clk);
        check("tmo_err", 32'(boot_err), 32'(1'b1));
        check("tmo_stall", 32'(cpu_stall), 32'(1'b1));
        check("tmo_busy", 32'(boot_busy), 32'(1'b0));
        tick();
        build(3);
        run_load(prog, 1, 1'b0);

        // rx_rdy held high throughout: one consume per byte state, none in WRITE.
        build(4);
        run_load(prog, 0, 1'b0);

        // Randomized loads with gaps and ignored mid-load boot_req pulses.
        for (int it = 0; it < 10; it++) begin
            build(int'($urandom_range(6, 0)));
            run_load(prog, 3, 1'b1);
        end

        // Reset after the 4th byte: no write has happened yet.
        prog.delete();
        foreach (dir_prog[i]) prog.push_back(dir_prog[i]);
        we0 = we_n;
        pulse_req();
        for (int i = 0; i < 4; i++) send_byte(prog[i], 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_stall", 32'(cpu_stall), 32'(1'b0));
        check("mrst_busy", 32'(boot_busy), 32'(1'b0));
        check("mrst_clr", 32'(rx_clr_rdy), 32'(1'b0));
        check("mrst_we", 32'(im_we), 32'(1'b0));
        rx_rdy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst_no_write", we_n - we0, 0);

        // Reset after the first WRITE cycle: IM[0] already written.
        we0 = we_n;
        pulse_req();
        for (int i = 0; i < 5; i++) send_byte(prog[i], 0, 1'b0);
        rx_rdy = 1'b0;
        tick();
        check("mrst2_words_pre", 32'(words_loaded), 32'(16'd1));
        rst_n = 1'b0;
        #1;
        check("mrst2_words", 32'(words_loaded), 32'(16'd0));
        check("mrst2_wdata", 32'(im_wdata), 32'(17'd0));
        check("mrst2_stall", 32'(cpu_stall), 32'(1'b0));
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst2_one_write", we_n - we0, 1);
        if (wr_data.size() > 0) check("mrst2_data", 32'(wr_data[wr_data.size() - 1]), 32'(17'h11234));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of run, expected completion within 50000 cycles");
        $fatal(1);
    end

endmodule
